div_sched: RTL
==============

# div_sched

Round-robin scheduler that shares one iterative 32-bit divider between `NREQ` requesters (e.g. issue slots or threads). It sits between the requesters' valid/ready ports and the divider's start/result interface. It drives the divider's edge-triggered start, holds operands and mode bits stable for the whole operation, and returns each result with the requester id and tag. It also supports pipeline flush.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `TAGW`, 4: width of the per-request tag.
- `DIV_LAT`, 34: cycles from the start cycle to the cycle in which `div_result` is final.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_ready` out NREQ: grant. Request `i` is accepted when `req_valid[i] && req_ready[i]`.
- `req_src1` in NREQ*33: dividend per requester. Slice `i` is `[33*i+32:33*i]`.
- `req_src2` in NREQ*32: divisor per requester.
- `req_div_mod` in NREQ: 1 selects remainder, 0 selects quotient.
- `req_revert` in NREQ: 1 selects a two's-complement negated result.
- `req_tag` in NREQ*TAGW: opaque tag, returned with the response.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_id` out max(1,clog2(NREQ)): index of the requester that owns the response.
- `rsp_tag` out TAGW: tag of the accepted request.
- `rsp_result` out 32: divider result.
- `rsp_ov` out 1: divisor was zero.
- `flush` in 1: abandon any request that is in flight or awaiting response.
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_src1` out 33: dividend to the divider.
- `div_src2` out 32: divisor to the divider.
- `div_div_mod` out 1: mode to the divider.
- `div_revert` out 1: negate control to the divider.
- `div_result` in 32: divider result.
- `div_ov` in 1: divider overflow (divide-by-zero).

## Operation
State machine: IDLE, BUSY, RESP.

- **IDLE**
  - Arbitration picks the first `req_valid` requester searching from `rr_ptr+1` modulo NREQ.
  - `req_ready` is one-hot for that winner only, and is combinational from `req_valid` in IDLE.
  - On accept:
    - latch src1, src2, div_mod, revert and tag into hold registers;
    - latch the winner index;
    - set `rr_ptr` to the winner;
    - clear `cnt`;
    - go to BUSY.
- **BUSY**
  - `div_start` is 1 only in the first BUSY cycle (`cnt==0`) and 0 otherwise.
  - `cnt` increments each cycle.
  - In the cycle where `cnt==DIV_LAT`, capture `div_result` and `div_ov` into `rsp_result` and `rsp_ov`, then go to RESP.
- **RESP**
  - `rsp_valid` is 1.
  - When `rsp_ready` is high, go to IDLE.
  - No request is accepted in RESP.
- **Divider outputs**
  - `div_src1`, `div_src2`, `div_div_mod` and `div_revert` are driven from the hold registers at all times.
  - They are stable from the start cycle through the capture cycle. The divider evaluates mode and negate at completion, so this is mandatory.
- **Start pulse**
  - `div_start` is low in every cycle except the BUSY first cycle.
  - So there is always at least one low cycle before each pulse, which the divider's edge detector needs.
- **`flush`** (highest priority, any state)
  - Next state is IDLE.
  - `rsp_valid` drops the next cycle and `req_ready` is 0 in the flush cycle.
  - Nothing is accepted or captured in that cycle.
  - The divider is not aborted. The next `div_start` reloads it, and the abandoned operation never reaches `rsp_*`.
- **Bits not examined**
  - `rsp_ov` is passed through and does not alter `rsp_result`.
  - The scheduler does not interpret `div_src1[32]`.

## Timing
- **Reset:**
  - State IDLE, `cnt` 0, `rr_ptr` NREQ-1 (so requester 0 has first priority).
  - `rsp_valid`, `div_start` and `req_ready` are 0.
  - `rsp_result`, `rsp_ov`, `rsp_id` and `rsp_tag` are 0.
  - Hold registers are 0.
- **Latency:**
  - Accept in cycle A, `div_start` in cycle A+1.
  - Capture in cycle A+1+DIV_LAT.
  - `rsp_valid` from cycle A+2+DIV_LAT, which is A+36 by default.
- **Throughput:** the next accept is possible in the cycle after the `rsp_valid && rsp_ready` handshake.
- **Back-pressure:** `rsp_*` hold stable while `rsp_valid && !rsp_ready`.
- **`req_valid` dropped:** if `req_valid` falls in BUSY or RESP, nothing changes, because the operation is already latched.
- **Simultaneous `flush` and `rsp_ready` in RESP:** IDLE, response discarded (not counted as delivered).
- **Reset mid-operation:** immediate return to reset values. The divider's own reset is `!reset_n`.

## Test plan
- **Single request:**
  - req0 with src1=100, src2=7, div_mod=0, revert=0, tag=3, accepted in cycle 10.
  - Expect `div_start` only in cycle 11.
  - Expect `rsp_valid` in cycle 46 with result=14, id=0, tag=3, ov=0.
- **Remainder and negate:**
  - src1=100, src2=7, div_mod=1 → result=2.
  - div_mod=0, revert=1 → result=0xFFFFFFF2.
- **Round-robin:**
  - req0 and req1 both held valid for 4 operations.
  - Expect grant order 0,1,0,1, with `req_ready` never two-hot.
  - Expect each `div_start` preceded by a low cycle.
- **Back-pressure:**
  - Hold `rsp_ready` low for 20 cycles after `rsp_valid`.
  - Expect `rsp_*` stable, `req_ready` 0, and `div_start` not pulsed.
  - Release → IDLE, then accept the next request the following cycle.
- **Divide-by-zero:** src2=0 → `rsp_ov`=1, response delivered on normal timing.
- **Flush and reset:**
  - `flush` at `cnt`=10 → IDLE, no `rsp_valid`; a new request (50/5) accepted right after returns 10.
  - `reset_n` low mid-BUSY → all outputs 0, and the first post-reset grant goes to req0.

Source files
------------

// File: rtl/div_sched.sv
// Round-robin scheduler that shares one iterative 32-bit divider between NREQ requesters.
// Operands are held stable for the whole operation; each result returns with its requester id and tag.
module div_sched #(
    parameter  int NREQ    = 2,
    parameter  int TAGW    = 4,
    parameter  int DIV_LAT = 34,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*33-1:0]   req_src1,
    input  logic [NREQ*32-1:0]   req_src2,
    input  logic [NREQ-1:0]      req_div_mod,
    input  logic [NREQ-1:0]      req_revert,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [TAGW-1:0]      rsp_tag,
    output logic [31:0]          rsp_result,
    output logic                 rsp_ov,
    input  logic                 flush,
    output logic                 div_start,
    output logic [32:0]          div_src1,
    output logic [31:0]          div_src2,
    output logic                 div_div_mod,
    output logic                 div_revert,
    input  logic [31:0]          div_result,
    input  logic                 div_ov
);

    localparam int CNTW = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [32:0]       src1_q, src1_d;
    logic [31:0]       src2_q, src2_d;
    logic              mod_q, mod_d;
    logic              rev_q, rev_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [31:0]       result_q, result_d;
    logic              ov_q, ov_d;

    logic [IDW-1:0]    win;
    logic              found;
    logic [NREQ-1:0]   grant;
    logic              accept;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin : arbiter
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign grant     = found ? (NREQ'(1) << win) : '0;
    assign req_ready = (state_q == IDLE && !flush) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        mod_d    = mod_q;
        rev_d    = rev_q;
        tag_d    = tag_q;
        result_d = result_q;
        ov_d     = ov_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        src1_d   = req_src1[33*int'(win) +: 33];
                        src2_d   = req_src2[32*int'(win) +: 32];
                        mod_d    = req_div_mod[win];
                        rev_d    = req_revert[win];
                        tag_d    = req_tag[TAGW*int'(win) +: TAGW];
                        id_d     = win;
                        rr_ptr_d = win;
                        cnt_d    = '0;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(DIV_LAT)) begin
                        result_d = div_result;
                        ov_d     = div_ov;
                        state_d  = RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= IDW'(NREQ - 1);
            id_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            mod_q    <= 1'b0;
            rev_q    <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            mod_q    <= mod_d;
            rev_q    <= rev_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            ov_q     <= ov_d;
        end
    end

    // The divider edge-detects start, so it must only pulse in the first busy cycle.
    assign div_start   = (state_q == BUSY) && (cnt_q == '0);
    assign div_src1    = src1_q;
    assign div_src2    = src2_q;
    assign div_div_mod = mod_q;
    assign div_revert  = rev_q;

    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_tag     = tag_q;
    assign rsp_result  = result_q;
    assign rsp_ov      = ov_q;

endmodule
